// File: rtl/disp_7_seg_pkg.sv
// Shared glyph patterns, digit codes and FSM state type for the 7-segment display path.
// Glyph patterns are active-high {g,f,e,d,c,b,a}.
package disp_7_seg_pkg;

  localparam logic [4:0] CODE_BLANK   = 5'd16;
  localparam logic [4:0] CODE_MINUS   = 5'd17;
  localparam logic [4:0] CODE_INVALID = 5'd31;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_MINUS = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_EVAL = 2'd1,
    ST_HOLD = 2'd2
  } rx_state_e;

  function automatic logic is_one_hot(input logic [7:0] bits);
    return (bits != 8'd0) && ((bits & (bits - 8'd1)) == 8'd0);
  endfunction

  function automatic logic [2:0] one_hot_index(input logic [7:0] bits);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bits[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // A frame counts as clean only if none of its eight slots holds the invalid code.
  function automatic logic frame_has_invalid(input logic [39:0] frame);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (frame[5*i +: 5] == CODE_INVALID) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational glyph decoder: active-high segment pattern {g,f,e,d,c,b,a} to 5-bit digit code.
module seg_decode
  import disp_7_seg_pkg::*;
(
  input  logic [6:0] seg_on,
  output logic [4:0] code
);

  always_comb begin
    code = CODE_INVALID;
    case (seg_on)
      GLYPH_0:     code = 5'd0;
      GLYPH_1:     code = 5'd1;
      GLYPH_2:     code = 5'd2;
      GLYPH_3:     code = 5'd3;
      GLYPH_4:     code = 5'd4;
      GLYPH_5:     code = 5'd5;
      GLYPH_6:     code = 5'd6;
      GLYPH_7:     code = 5'd7;
      GLYPH_8:     code = 5'd8;
      GLYPH_9:     code = 5'd9;
      GLYPH_A:     code = 5'd10;
      GLYPH_B:     code = 5'd11;
      GLYPH_C:     code = 5'd12;
      GLYPH_D:     code = 5'd13;
      GLYPH_E:     code = 5'd14;
      GLYPH_F:     code = 5'd15;
      GLYPH_BLANK: code = CODE_BLANK;
      GLYPH_MINUS: code = CODE_MINUS;
      default:     code = CODE_INVALID;
    endcase
  end

endmodule

// File: rtl/disp_7_seg_rx.sv
// Receive-side monitor for a multiplexed 8-digit 7-segment display: decodes scanned glyphs into frames.
// Optional scan-stall detector is built when DISP_RX_TIMEOUT_EN is defined.
module disp_7_seg_rx
  import disp_7_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 262144
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [7:0]  AN,
  input  logic [6:0]  seg,
  output logic [39:0] digits,
  output logic        frame_valid,
  output logic [2:0]  cur_index,
  output logic        multi_an_err,
  output logic        glyph_err,
  output logic        stalled
);

  if ((STABLE_CYCLES < 2) || (STABLE_CYCLES > 255) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("disp_7_seg_rx: STABLE_CYCLES must be 2..255 and TIMEOUT_CYCLES at least 1");
  end

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES - 1);

  logic [14:0] meta_q, meta_d;
  logic [14:0] sync_q, sync_d;
  logic [14:0] prev_q, prev_d;
  logic [14:0] held_q, held_d;
  logic [7:0]  cnt_q, cnt_d;
  rx_state_e   state_q, state_d;
  logic [39:0] shadow_q, shadow_d;
  logic [7:0]  seen_q, seen_d;
  logic [39:0] digits_q, digits_d;
  logic        frame_valid_q, frame_valid_d;
  logic [2:0]  cur_index_q, cur_index_d;
  logic        multi_q, multi_d;
  logic        glyph_q, glyph_d;

  logic        in_change;
  logic [7:0]  an_on;
  logic [6:0]  seg_on;
  logic [4:0]  dec_code;
  logic [2:0]  an_idx;
  logic [7:0]  seen_next;
  logic        stalled_w;

  // Decode works from prev_q, the last sample that belonged to the stable run.
  assign in_change = (sync_q != prev_q);
  assign an_on     = ~prev_q[14:7];
  assign seg_on    = ~prev_q[6:0];
  assign an_idx    = one_hot_index(an_on);

  seg_decode u_seg_decode (
    .seg_on (seg_on),
    .code   (dec_code)
  );

  always_comb begin
    meta_d = {AN, seg};
    sync_d = meta_q;
    prev_d = sync_q;
    cnt_d  = cnt_q;
    if (in_change) begin
      cnt_d = 8'd0;
    end else if (cnt_q != STABLE_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d       = state_q;
    held_d        = held_q;
    shadow_d      = shadow_q;
    seen_next     = seen_q;
    digits_d      = digits_q;
    frame_valid_d = 1'b0;
    cur_index_d   = cur_index_q;
    multi_d       = 1'b0;
    glyph_d       = glyph_q;

    case (state_q)
      ST_WAIT: begin
        if (!in_change && (cnt_q == STABLE_MAX)) state_d = ST_EVAL;
      end

      ST_EVAL: begin
        state_d = ST_HOLD;
        held_d  = prev_q;
        if (is_one_hot(an_on)) begin
          for (int i = 0; i < 8; i++) begin
            if (an_idx == 3'(i)) shadow_d[5*i +: 5] = dec_code;
          end
          seen_next   = seen_q | (8'd1 << an_idx);
          cur_index_d = an_idx;
          if (dec_code == CODE_INVALID) glyph_d = 1'b1;
          if (seen_next == 8'hFF) begin
            digits_d      = shadow_d;
            frame_valid_d = 1'b1;
            seen_next     = 8'd0;
            if (!frame_has_invalid(shadow_d)) glyph_d = 1'b0;
          end
        end else if (an_on != 8'd0) begin
          multi_d = 1'b1;
        end
      end

      ST_HOLD: begin
        // Compare against the evaluated sample so a change that landed during EVAL still releases HOLD.
        if (sync_q != held_q) state_d = ST_WAIT;
      end

      default: state_d = ST_WAIT;
    endcase

    seen_d = stalled_w ? 8'd0 : seen_next;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      meta_q        <= '1;
      sync_q        <= '1;
      prev_q        <= '1;
      held_q        <= '1;
      cnt_q         <= '0;
      state_q       <= ST_WAIT;
      shadow_q      <= '0;
      seen_q        <= '0;
      digits_q      <= '0;
      frame_valid_q <= 1'b0;
      cur_index_q   <= '0;
      multi_q       <= 1'b0;
      glyph_q       <= 1'b0;
    end else begin
      meta_q        <= meta_d;
      sync_q        <= sync_d;
      prev_q        <= prev_d;
      held_q        <= held_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      seen_q        <= seen_d;
      digits_q      <= digits_d;
      frame_valid_q <= frame_valid_d;
      cur_index_q   <= cur_index_d;
      multi_q       <= multi_d;
      glyph_q       <= glyph_d;
    end
  end

`ifdef DISP_RX_TIMEOUT_EN
  localparam int TO_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_W     = (TO_W_RAW > 18) ? TO_W_RAW : 18;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            an_change;

  // Counts cycles since the anodes last moved, saturating at the limit.
  assign an_change = (sync_q[14:7] != prev_q[14:7]);

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (an_change) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_LIMIT) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign stalled_w = (to_cnt_q == TO_LIMIT);
`else
  assign stalled_w = 1'b0;
`endif

  assign digits       = digits_q;
  assign frame_valid  = frame_valid_q;
  assign cur_index    = cur_index_q;
  assign multi_an_err = multi_q;
  assign glyph_err    = glyph_q;
  assign stalled      = stalled_w;

endmodule

// File: tb/tb_disp_7_seg_rx.sv
// Self-checking bench for disp_7_seg_rx: behavioural frame model compared every cycle plus literal checkpoints.
// Covers the DISP_RX_TIMEOUT_EN build when that macro is defined.
module tb_disp_7_seg_rx;

  localparam int N  = 16;
  localparam int TO = 1000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  an    = 8'hFF;
  logic [6:0]  seg_n = 7'h7F;
  logic [39:0] digits;
  logic        frame_valid;
  logic [2:0]  cur_index;
  logic        multi_an_err;
  logic        glyph_err;
  logic        stalled;

  int checks   = 0;
  int failures = 0;
  int fv_count = 0;
  int ma_count = 0;

  disp_7_seg_rx #(
    .STABLE_CYCLES  (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK100MHZ    (clk),
    .CPU_RESETN   (rst_n),
    .AN           (an),
    .seg          (seg_n),
    .digits       (digits),
    .frame_valid  (frame_valid),
    .cur_index    (cur_index),
    .multi_an_err (multi_an_err),
    .glyph_err    (glyph_err),
    .stalled      (stalled)
  );

  always #5 clk = ~clk;

  // Active-high {g,f,e,d,c,b,a} for codes 0..15, 16 = blank, 17 = minus.
  function automatic logic [6:0] pat(input int code);
    case (code)
      0: return 7'b0111111;   1: return 7'b0000110;   2: return 7'b1011011;
      3: return 7'b1001111;   4: return 7'b1100110;   5: return 7'b1101101;
      6: return 7'b1111101;   7: return 7'b0000111;   8: return 7'b1111111;
      9: return 7'b1101111;  10: return 7'b1110111;  11: return 7'b1111100;
      12: return 7'b0111001; 13: return 7'b1011110;  14: return 7'b1111001;
      15: return 7'b1110001; 17: return 7'b1000000;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic int decode_model(input logic [6:0] on);
    int code;
    code = 31;
    for (int c = 17; c >= 0; c--) begin
      if (pat(c) == on) code = c;
    end
    return code;
  endfunction

  task automatic checkOutput(input string name, input logic [39:0] actual, input logic [39:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a pin pattern unchanged for N+1 sampled cycles is evaluated once; results appear 3 edges later.
  logic [39:0] m_digits = '0;
  logic        m_fv     = 1'b0;
  logic [2:0]  m_cur    = '0;
  logic        m_multi  = 1'b0;
  logic        m_glyph  = 1'b0;
  logic [7:0]  m_seen   = '0;
  int          m_shadow [8];
  logic [14:0] last_pin = '1;
  int          run_len  = 1;
  int          ev_kind [3];
  int          ev_idx  [3];
  int          ev_code [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_digits = '0; m_fv = 1'b0; m_cur = '0; m_multi = 1'b0; m_glyph = 1'b0; m_seen = '0;
      last_pin = '1; run_len = 1;
      for (int i = 0; i < 8; i++) m_shadow[i] = 0;
      for (int i = 0; i < 3; i++) begin ev_kind[i] = 0; ev_idx[i] = 0; ev_code[i] = 0; end
    end else begin
      logic [14:0] pin;
      logic [7:0]  lit;
      m_fv = 1'b0;
      m_multi = 1'b0;
      if (ev_kind[2] == 1) begin
        m_shadow[ev_idx[2]] = ev_code[2];
        m_seen[ev_idx[2]] = 1'b1;
        m_cur = 3'(ev_idx[2]);
        if (ev_code[2] == 31) m_glyph = 1'b1;
        if (m_seen == 8'hFF) begin
          bit bad;
          bad = 1'b0;
          for (int i = 0; i < 8; i++) begin
            m_digits[5*i +: 5] = 5'(m_shadow[i]);
            if (m_shadow[i] == 31) bad = 1'b1;
          end
          m_fv = 1'b1;
          m_seen = '0;
          if (!bad) m_glyph = 1'b0;
        end
      end else if (ev_kind[2] == 2) begin
        m_multi = 1'b1;
      end
      for (int i = 2; i > 0; i--) begin
        ev_kind[i] = ev_kind[i-1]; ev_idx[i] = ev_idx[i-1]; ev_code[i] = ev_code[i-1];
      end
      ev_kind[0] = 0;
      pin = {an, seg_n};
      if (pin == last_pin) run_len++;
      else begin last_pin = pin; run_len = 1; end
      if (run_len == N + 1) begin
        lit = ~an;
        if ($countones(lit) == 1) begin
          ev_kind[0] = 1;
          for (int i = 0; i < 8; i++) if (lit[i]) ev_idx[0] = i;
          ev_code[0] = decode_model(~seg_n);
        end else if ($countones(lit) > 1) begin
          ev_kind[0] = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("digits", digits, m_digits);
    checkOutput("frame_valid", 40'(frame_valid), 40'(m_fv));
    checkOutput("cur_index", 40'(cur_index), 40'(m_cur));
    checkOutput("multi_an_err", 40'(multi_an_err), 40'(m_multi));
    checkOutput("glyph_err", 40'(glyph_err), 40'(m_glyph));
`ifndef DISP_RX_TIMEOUT_EN
    checkOutput("stalled", 40'(stalled), 40'd0);
`endif
    if (frame_valid) fv_count++;
    if (multi_an_err) ma_count++;
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [6:0] s, input int cycles);
    an = a;
    seg_n = s;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic scanFrame(input logic [7:0][6:0] on_pats, input int count);
    logic [7:0] a;
    for (int i = 0; i < count; i++) begin
      a = 8'd1 << i;
      applyStimulus(~a, ~on_pats[i], 20);
    end
    applyStimulus(8'hFF, 7'h7F, 12);
  endtask

  task automatic checkLiterals(input string tag, input logic [39:0] exp_digits,
                               input logic [2:0] exp_cur, input logic exp_glyph);
    @(negedge clk);
    #1;
    checkOutput({tag, "_digits"}, digits, exp_digits);
    checkOutput({tag, "_cur_index"}, 40'(cur_index), 40'(exp_cur));
    checkOutput({tag, "_glyph_err"}, 40'(glyph_err), 40'(exp_glyph));
  endtask

  logic [7:0][6:0] frame_a, frame_bad, frame_b, frame_c;
  int fv0, ma0;

  initial begin
    for (int i = 0; i < 8; i++) begin
      frame_a[i] = pat(i);
      frame_bad[i] = pat(i);
      frame_b[i] = pat(8 + i);
      frame_c[i] = pat(9 - i);
    end
    frame_bad[3] = 7'b1010101;
    frame_c[0] = pat(17);
    frame_c[1] = pat(16);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("reset_digits", digits, 40'd0);
    checkOutput("reset_frame_valid", 40'(frame_valid), 40'd0);
    checkOutput("reset_cur_index", 40'(cur_index), 40'd0);
    checkOutput("reset_multi", 40'(multi_an_err), 40'd0);
    checkOutput("reset_glyph", 40'(glyph_err), 40'd0);
    checkOutput("reset_stalled", 40'(stalled), 40'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(8'hFF, 7'h7F, 20);

    $display("[TB] scan 01234567");
    fv0 = fv_count;
    scanFrame(frame_a, 8);
    checkLiterals("scan_a", {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}, 3'd7, 1'b0);
    checkOutput("scan_a_fv_count", 40'(fv_count - fv0), 40'd1);

    $display("[TB] seg toggling every 4 cycles");
    fv0 = fv_count;
    for (int k = 0; k < 10; k++) applyStimulus(8'hFE, (k % 2) ? ~pat(9) : ~pat(8), 4);
    applyStimulus(8'hFF, 7'h7F, 25);
    checkLiterals("toggle", {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}, 3'd7, 1'b0);
    checkOutput("toggle_fv_count", 40'(fv_count - fv0), 40'd0);

    $display("[TB] two anodes low");
    fv0 = fv_count;
    ma0 = ma_count;
    applyStimulus(8'hFC, ~pat(1), 30);
    applyStimulus(8'hFF, 7'h7F, 25);
    checkLiterals("multi", {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}, 3'd7, 1'b0);
    checkOutput("multi_pulse_count", 40'(ma_count - ma0), 40'd1);
    checkOutput("multi_fv_count", 40'(fv_count - fv0), 40'd0);

    $display("[TB] unknown glyph on digit 3");
    scanFrame(frame_bad, 8);
    checkLiterals("glyph", {5'd7, 5'd6, 5'd5, 5'd4, 5'd31, 5'd2, 5'd1, 5'd0}, 3'd7, 1'b1);
    scanFrame(frame_a, 8);
    checkLiterals("glyph_clear", {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}, 3'd7, 1'b0);

    $display("[TB] hex, blank and minus glyphs");
    scanFrame(frame_b, 8);
    checkLiterals("hex", {5'd15, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd9, 5'd8}, 3'd7, 1'b0);
    scanFrame(frame_c, 8);
    checkLiterals("special", {5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd16, 5'd17}, 3'd7, 1'b0);

    $display("[TB] reset after five digits");
    scanFrame(frame_a, 5);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("midreset_digits", digits, 40'd0);
    checkOutput("midreset_cur_index", 40'(cur_index), 40'd0);
    checkOutput("midreset_glyph", 40'(glyph_err), 40'd0);
    checkOutput("midreset_fv", 40'(frame_valid), 40'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(8'hFF, 7'h7F, 20);
    fv0 = fv_count;
    scanFrame(frame_a, 8);
    checkLiterals("post_reset", {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}, 3'd7, 1'b0);
    checkOutput("post_reset_fv_count", 40'(fv_count - fv0), 40'd1);

`ifdef DISP_RX_TIMEOUT_EN
    $display("[TB] frozen scan timeout");
    applyStimulus(8'hF7, ~pat(5), TO + 20);
    checkOutput("stalled_set", 40'(stalled), 40'd1);
    applyStimulus(8'hFF, 7'h7F, 3);
    @(negedge clk); #1;
    checkOutput("stalled_clear", 40'(stalled), 40'd0);
    applyStimulus(8'hFF, 7'h7F, 10);
    fv0 = fv_count;
    scanFrame(frame_a, 8);
    checkOutput("after_stall_fv_count", 40'(fv_count - fv0), 40'd1);
`else
    $display("[TB] frozen scan without timeout feature");
    applyStimulus(8'hF7, ~pat(5), 300);
    checkOutput("stalled_tied_low", 40'(stalled), 40'd0);
    applyStimulus(8'hFF, 7'h7F, 10);
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
